// File: rtl/s2qed_fetch_lockstep.sv
`default_nettype none
// ============================================================================
// Module   : s2qed_fetch_lockstep
// Purpose  : Shares one instruction-memory read port between two lockstep
//            cores and hands both the same word in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module s2qed_fetch_lockstep #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c0_req,
  input  logic [AW-1:0] c0_addr,
  input  logic          c1_req,
  input  logic [AW-1:0] c1_addr,
  output logic          c0_gnt,
  output logic          c1_gnt,
  output logic [DW-1:0] c0_rdata,
  output logic [DW-1:0] c1_rdata,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          mismatch,
  output logic          timeout,
  output logic [15:0]   fetch_cnt
);

  localparam int c_cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT0 = 3'd1,
    S_WAIT1 = 3'd2,
    S_MEM   = 3'd3,
    S_RESP  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_wait_cnt;

  logic                 w_pair;
  logic                 w_addr_eq;
  logic                 w_drop;
  logic [c_cnt_w-1:0]   w_cnt_next;

  always_comb begin
    w_pair     = c0_req && c1_req;
    w_addr_eq  = (c0_addr == c1_addr);
    w_drop     = ((r_state == S_WAIT0) && !c0_req) ||
                 ((r_state == S_WAIT1) && !c1_req);
    w_cnt_next = r_wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      c0_gnt     <= 1'b0;
      c1_gnt     <= 1'b0;
      c0_rdata   <= '0;
      c1_rdata   <= '0;
      mismatch   <= 1'b0;
      timeout    <= 1'b0;
      fetch_cnt  <= '0;
    end else begin
      c0_gnt <= 1'b0;
      c1_gnt <= 1'b0;
      case (r_state)
        S_IDLE, S_WAIT0, S_WAIT1: begin
          if (w_drop) begin
            r_state <= S_IDLE;
          end else if (w_pair) begin
            // A partner arriving on the timeout cycle still wins here.
            if (w_addr_eq) begin
              r_state  <= S_MEM;
              mem_req  <= 1'b1;
              mem_addr <= c0_addr;
            end else begin
              r_state  <= S_ERROR;
              mismatch <= 1'b1;
            end
          end else if (r_state == S_IDLE) begin
            if (c0_req) begin
              r_state    <= S_WAIT0;
              r_wait_cnt <= '0;
            end else if (c1_req) begin
              r_state    <= S_WAIT1;
              r_wait_cnt <= '0;
            end
          end else if (w_cnt_next == c_timeout) begin
            r_state <= S_ERROR;
            timeout <= 1'b1;
          end else begin
            r_wait_cnt <= w_cnt_next;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            r_state   <= S_RESP;
            mem_req   <= 1'b0;
            c0_rdata  <= mem_rdata;
            c1_rdata  <= mem_rdata;
            c0_gnt    <= 1'b1;
            c1_gnt    <= 1'b1;
            fetch_cnt <= fetch_cnt + 16'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        S_ERROR: begin
          r_state <= S_ERROR;
        end
        default: begin
          r_state <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/s2qed_fetch_lockstep.md
# s2qed_fetch_lockstep

Lockstep instruction-fetch controller for the S2QED dual-core harness. It shares a single instruction-memory read port between two mriscvcore instances (core 0, core 1) and guarantees both cores receive the identical instruction word in the same cycle. The S2QED checker relies on the same-instruction property, and this block is what sequences it. Address divergence and one-sided stalls are detected and reported as sticky errors; after an error the block freezes both cores until reset.

## Interface
- AW, 32, fetch address width
- DW, 32, instruction word width
- TIMEOUT, 15, maximum cycles one core may wait for its partner; must be ≥1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- c0_req / c1_req  in  1  core fetch request; held until grant
- c0_addr / c1_addr  in  AW  fetch address; stable while req high
- c0_gnt / c1_gnt  out  1  one-cycle grant pulse; always asserted together
- c0_rdata / c1_rdata  out  DW  instruction word, valid when gnt high
- mem_req  out  1  memory read request; held until mem_ack
- mem_addr  out  AW  memory read address; stable while mem_req high
- mem_ack  in  1  one-cycle read completion
- mem_rdata  in  DW  read data, valid with mem_ack
- mismatch  out  1  sticky; the cores requested different addresses
- timeout  out  1  sticky; one core waited more than TIMEOUT cycles
- fetch_cnt  out  16  number of completed lockstep fetches

## Operation
- States: IDLE, WAIT0 (core 0 pending, core 1 absent), WAIT1 (core 1 pending, core 0 absent), MEM, RESP, ERROR.
- IDLE:
  - both req high, addresses equal → latch address into mem_addr, go to MEM.
  - both req high, addresses differ → set mismatch, go to ERROR.
  - only c0_req → WAIT0; only c1_req → WAIT1. Clear the wait counter on entry.
- WAIT0 / WAIT1:
  - partner req rises → compare addresses using the same rules as IDLE (MEM or ERROR).
  - pending req drops (protocol violation) → IDLE with no flag.
  - otherwise the wait counter increments.
  - counter == TIMEOUT and partner still absent → set timeout, go to ERROR.
  - partner arriving in that same cycle takes priority over the timeout.
- MEM: mem_req high. On mem_ack, register mem_rdata into both rdata outputs and go to RESP.
- RESP:
  - c0_gnt = c1_gnt = 1 for exactly this cycle; fetch_cnt increments (wraps 0xFFFF→0x0000).
  - next state is IDLE; req inputs sampled during RESP are ignored.
- ERROR: mem_req, gnts held 0. Flags and fetch_cnt hold. Only rst exits.
- Wait counter width: $clog2(TIMEOUT+1).
- mem_ack outside MEM is ignored, e.g. a late ack after reset.

## Timing
- Reset values: state IDLE; mem_req 0; mem_addr 0; both gnt 0; both rdata 0; mismatch 0; timeout 0; fetch_cnt 0; wait counter 0.
- Both requests present at cycle t in IDLE → mem_req=1 at t+1.
- mem_ack at cycle m → gnts and rdata at m+1 → IDLE at m+2. Earliest next mem_req is m+3.
- Minimum fetch latency, with mem_ack in the first cycle of MEM: req@t → gnt@t+2.
- Staggered arrival: core 0 at t, core 1 at t+k (k ≤ TIMEOUT) → mem_req at t+k+1.
- Timeout: core 0 alone from cycle t → timeout=1 at t+TIMEOUT+1.
- Mismatch flag is registered one cycle after the compare.
- rst high in any state → reset values on the next edge, including mid-MEM: mem_req drops and the pending fetch is abandoned.

## Test plan
- Both cores request addr 0x100 at the same time; mem_ack after 2 cycles with 0x00500093 → both gnts pulse once in the same cycle, both rdata=0x00500093, fetch_cnt=1, mem_req asserted exactly once.
- Core 0 requests 0x200; core 1 joins 3 cycles later (TIMEOUT=15) → single mem_req with mem_addr=0x200 the cycle after core 1 joins; both gnts simultaneous; no flags.
- Core 0 requests 0x300, core 1 requests 0x304 in the same cycle → mismatch=1 next cycle; no mem_req; gnts stay 0 through a further 20 cycles of requests.
- Core 1 requests alone with TIMEOUT=4 → timeout=1 exactly 5 cycles after the request; ERROR holds until rst; after rst all outputs return to reset values.
- rst asserted while in MEM, with mem_ack arriving the cycle after reset → mem_req=0, no gnt, fetch_cnt=0.
- Preload fetch_cnt near wrap (0xFFFF) via 65535 back-to-back fetches or forced state → the next fetch gives fetch_cnt=0x0000.
